// File: rtl/plot_scheduler_if.sv
// Plot-port bundle between the game logic and the plot scheduler.
// The master side drives player data and requests; the scheduler (slave) returns the plot stream.
interface plot_scheduler_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3
);
  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] p_pos;
  logic [NUM_PLAYERS*COLOUR_W-1:0]  p_colour;
  logic [NUM_PLAYERS-1:0]           p_en;
  logic                             start;
  logic                             timer_tick;
  logic [X_W-1:0]                   x;
  logic [Y_W-1:0]                   y;
  logic [COLOUR_W-1:0]              colour;
  logic                             plot;
  logic                             running;
  logic [X_W-1:0]                   timer_x;

  modport master (
    output p_pos, p_colour, p_en, start, timer_tick,
    input  x, y, colour, plot, running, timer_x
  );

  modport slave (
    input  p_pos, p_colour, p_en, start, timer_tick,
    output x, y, colour, plot, running, timer_x
  );
endinterface

// File: rtl/plot_scheduler.sv
// Time-multiplexes player pixels and the countdown-bar pixel onto one VGA plot port and owns the game run state.
// Optional screen-clear sweep before each game: define PLOT_SCHEDULER_CLEAR_EN.
module plot_scheduler #(
  parameter int                   NUM_PLAYERS  = 4,
  parameter int                   X_W          = 8,
  parameter int                   Y_W          = 7,
  parameter int                   COLOUR_W     = 3,
  parameter int                   TIMER_X_MAX  = 158,
  parameter int                   TIMER_Y      = 119,
  parameter logic [COLOUR_W-1:0]  TIMER_COLOUR = 3'b111,
  parameter int                   SCREEN_W     = 160,
  parameter int                   SCREEN_H     = 120,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR    = 3'b000
) (
  input logic              CLOCK_50,
  input logic              reset,
  plot_scheduler_if.slave  bus
);
  localparam int PW     = X_W + Y_W;
  localparam int SLOT_W = $clog2(NUM_PLAYERS + 1);
  localparam int NSLOT  = 1 << SLOT_W;
  localparam logic [SLOT_W-1:0] TIMER_SLOT = SLOT_W'(NUM_PLAYERS);

`ifdef PLOT_SCHEDULER_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
  logic [X_W-1:0]      r_timer_x, w_timer_nxt;
  logic [X_W-1:0]      r_x, w_x_nxt;
  logic [Y_W-1:0]      r_y, w_y_nxt;
  logic [COLOUR_W-1:0] r_colour, w_colour_nxt;
  logic                r_plot, w_plot_nxt;
  logic                r_running;
`ifdef PLOT_SCHEDULER_CLEAR_EN
  logic [X_W-1:0]      r_cx, w_cx_nxt;
  logic [Y_W-1:0]      r_cy, w_cy_nxt;
`endif

  // Per-slot views padded to a power of two so the slot counter indexes them directly
  logic [X_W-1:0]      w_px [NSLOT];
  logic [Y_W-1:0]      w_py [NSLOT];
  logic [COLOUR_W-1:0] w_pc [NSLOT];
  logic [NSLOT-1:0]    w_en;

  for (genvar g = 0; g < NSLOT; g++) begin : g_unpack
    if (g < NUM_PLAYERS) begin : g_player
      assign w_px[g] = bus.p_pos[g*PW + Y_W +: X_W];
      assign w_py[g] = bus.p_pos[g*PW +: Y_W];
      assign w_pc[g] = bus.p_colour[g*COLOUR_W +: COLOUR_W];
      assign w_en[g] = bus.p_en[g];
    end else begin : g_unused
      assign w_px[g] = '0;
      assign w_py[g] = '0;
      assign w_pc[g] = '0;
      assign w_en[g] = 1'b0;
    end
  end

  // Next-state, slot, timer and pixel selection
  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = '0;
    w_timer_nxt  = r_timer_x;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_colour_nxt = r_colour;
    w_plot_nxt   = 1'b0;
`ifdef PLOT_SCHEDULER_CLEAR_EN
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_timer_nxt = '0;
`ifdef PLOT_SCHEDULER_CLEAR_EN
          w_state_nxt = S_CLEAR;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
`else
          w_state_nxt = S_RUN;
`endif
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        // The final tick ends the game on this edge, so the bar never grows past its limit
        if (bus.timer_tick && (r_timer_x == X_W'(TIMER_X_MAX))) begin
          w_state_nxt = S_DONE;
        end else begin
          if (r_slot == TIMER_SLOT) begin
            w_x_nxt      = r_timer_x;
            w_y_nxt      = Y_W'(TIMER_Y);
            w_colour_nxt = TIMER_COLOUR;
            w_plot_nxt   = 1'b1;
            w_slot_nxt   = '0;
          end else begin
            w_plot_nxt = w_en[r_slot];
            w_slot_nxt = r_slot + SLOT_W'(1);
            if (w_en[r_slot]) begin
              w_x_nxt      = w_px[r_slot];
              w_y_nxt      = w_py[r_slot];
              w_colour_nxt = w_pc[r_slot];
            end else begin
              w_x_nxt = r_x;
            end
          end
          if (bus.timer_tick) begin
            w_timer_nxt = r_timer_x + X_W'(1);
          end else begin
            w_timer_nxt = r_timer_x;
          end
        end
      end
`ifdef PLOT_SCHEDULER_CLEAR_EN
      S_CLEAR: begin
        w_x_nxt      = r_cx;
        w_y_nxt      = r_cy;
        w_colour_nxt = BG_COLOUR;
        w_plot_nxt   = 1'b1;
        if (r_cx == X_W'(SCREEN_W - 1)) begin
          w_cx_nxt = '0;
          if (r_cy == Y_W'(SCREEN_H - 1)) begin
            w_cy_nxt    = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_cy_nxt = r_cy + Y_W'(1);
          end
        end else begin
          w_cx_nxt = r_cx + X_W'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered plot outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_timer_x <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
      r_running <= 1'b0;
`ifdef PLOT_SCHEDULER_CLEAR_EN
      r_cx      <= '0;
      r_cy      <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_timer_x <= w_timer_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_colour  <= w_colour_nxt;
      r_plot    <= w_plot_nxt;
      r_running <= (w_state_nxt == S_RUN);
`ifdef PLOT_SCHEDULER_CLEAR_EN
      r_cx      <= w_cx_nxt;
      r_cy      <= w_cy_nxt;
`endif
    end
  end

  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.colour  = r_colour;
  assign bus.plot    = r_plot;
  assign bus.running = r_running;
  assign bus.timer_x = r_timer_x;
endmodule

// File: tb/tb_plot_scheduler.sv
// Scoreboard bench for plot_scheduler at default parameters (clear sweep not built).
`timescale 1ns/100ps
module tb_plot_scheduler;
  localparam int NP = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int PW = XW + YW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plot_scheduler_if #(.NUM_PLAYERS(NP), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) u_if ();

  plot_scheduler dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [27:0] exp_q [$];

  // Reference model of the game: 0 idle, 1 run, 2 done
  int          m_st;
  int          m_slot;
  logic [7:0]  m_tx;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_c;
  logic        m_plot;
  logic        m_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] observed();
    return {u_if.x, u_if.y, u_if.colour, u_if.plot, u_if.running, u_if.timer_x};
  endfunction

  task automatic model_reset();
    m_st = 0; m_slot = 0; m_tx = 8'd0;
    m_x = 8'd0; m_y = 7'd0; m_c = 3'd0; m_plot = 1'b0; m_run = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic s, input logic t);
    m_plot = 1'b0;
    if (m_st != 1) begin
      if (s) begin
        m_st = 1; m_slot = 0; m_tx = 8'd0;
      end
    end else if (t && m_tx == 8'd158) begin
      m_st = 2; m_slot = 0;
    end else begin
      if (m_slot == NP) begin
        m_x = m_tx; m_y = 7'd119; m_c = 3'b111; m_plot = 1'b1;
        m_slot = 0;
      end else begin
        m_plot = u_if.p_en[m_slot];
        if (m_plot) begin
          {m_x, m_y} = u_if.p_pos[m_slot*PW +: PW];
          m_c = u_if.p_colour[m_slot*CW +: CW];
        end
        m_slot = m_slot + 1;
      end
      if (t) m_tx = m_tx + 8'd1;
    end
    m_run = (m_st == 1);
    exp_q.push_back({m_x, m_y, m_c, m_plot, m_run, m_tx});
  endtask

  task automatic cycle(input logic s, input logic t);
    logic [27:0] e;
    @(negedge clk);
    u_if.start = s;
    u_if.timer_tick = t;
    model_step(s, t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("plot_word", {4'd0, observed()}, {4'd0, e});
  endtask

  initial begin
    rst = 1'b1;
    u_if.p_pos = {8'd70, 7'd80, 8'd50, 7'd60, 8'd30, 7'd40, 8'd10, 7'd20};
    u_if.p_colour = {3'd4, 3'd3, 3'd2, 3'd1};
    u_if.p_en = 4'b1111;
    u_if.start = 1'b0;
    u_if.timer_tick = 1'b0;
    model_reset();
    #12;
    check_val("reset_outputs", {4'd0, observed()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle: ticks are ignored
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_val("running_after_start", {31'd0, u_if.running}, 32'd1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

    u_if.p_en = 4'b0101;
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0);
    u_if.p_en = 4'b1111;

    // 159 ticks: the last one ends the game
    for (int i = 0; i < 318; i++) cycle(1'b0, (i % 2) == 1);
    check_val("done_timer_x", {24'd0, u_if.timer_x}, 32'd158);
    check_val("done_running", {31'd0, u_if.running}, 32'd0);
    check_val("done_plot", {31'd0, u_if.plot}, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
    check_val("done_hold_timer", {24'd0, u_if.timer_x}, 32'd158);

    // Restart with a simultaneous tick: start wins
    cycle(1'b1, 1'b1);
    check_val("restart_timer_x", {24'd0, u_if.timer_x}, 32'd0);
    cycle(1'b0, 1'b0);
    check_val("restart_slot0_x", {24'd0, u_if.x}, 32'd10);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);

    // Asynchronous reset pulse between edges
    #2;
    rst = 1'b1;
    #0.5;
    check_val("async_plot", {31'd0, u_if.plot}, 32'd0);
    check_val("async_running", {31'd0, u_if.running}, 32'd0);
    check_val("async_timer_x", {24'd0, u_if.timer_x}, 32'd0);
    #0.5;
    rst = 1'b0;
    model_reset();

    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
